// File: rtl/hex_display_driver_if.sv
// hex_display_driver_if
//   Groups the load/data/mode request side and the tick/display result side of
//   hex_display_driver into one bundle.
//   Optional macro HEX_DP_EN adds the decimal-point pair dp_in / dp_n.
// Signals:
//   load      capture data (and dp_in) into the shadow register this cycle
//   data      4*DIGITS value, nibble k drives digit k
//   mode      00 static, 01 blink, 10 scroll, 11 static
//   lz_blank  1 = blank leading zero digits
//   tick      one-cycle pulse at each display tick
//   display   7*DIGITS active-low segments, {g,f,e,d,c,b,a} per digit
//   dp_in     (HEX_DP_EN) decimal points captured with data
//   dp_n      (HEX_DP_EN) active-low decimal point outputs
// Modports: master = board-side driver of the requests, slave = the display driver.
interface hex_display_driver_if #(
   parameter int unsigned DIGITS = 6
);
   logic                  load;
   logic [4*DIGITS-1:0]   data;
   logic [1:0]            mode;
   logic                  lz_blank;
   logic                  tick;
   logic [7*DIGITS-1:0]   display;
`ifdef HEX_DP_EN
   logic [DIGITS-1:0]     dp_in;
   logic [DIGITS-1:0]     dp_n;

   modport master (output load, data, mode, lz_blank, dp_in,
                   input  tick, display, dp_n);
   modport slave  (input  load, data, mode, lz_blank, dp_in,
                   output tick, display, dp_n);
`else
   modport master (output load, data, mode, lz_blank,
                   input  tick, display);
   modport slave  (input  load, data, mode, lz_blank,
                   output tick, display);
`endif
endinterface

// File: rtl/hex_display_driver.sv
// hex_display_driver
//   Registered multi-digit hex display driver. Captures a DIGITS-nibble value on
//   load and drives DIGITS active-low 7-segment digits in static, blink or scroll
//   mode, paced by an internal tick divider, with optional leading-zero blanking.
//   Optional macro HEX_DP_EN adds decimal points (dp_in captured on load, dp_n out).
// Ports:
//   clock   system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     hex_display_driver_if.slave (load, data, mode, lz_blank, tick, display
//           and, with HEX_DP_EN, dp_in / dp_n)
// Parameters:
//   DIGITS   number of digits (1..8)
//   TICK_DIV clocks per display tick (>=2)
//   CNT_W    tick counter width, 2^CNT_W >= TICK_DIV
module hex_display_driver #(
   parameter int unsigned DIGITS   = 6,
   parameter int unsigned TICK_DIV = 25000000,
   parameter int unsigned CNT_W    = 25
) (
   input  logic                  clock,
   input  logic                  resetn,
   hex_display_driver_if.slave   bus
);

   localparam int unsigned DW = 4 * DIGITS;
   localparam int unsigned SW = 7 * DIGITS;
   localparam logic [1:0] MODE_BLINK  = 2'b01;
   localparam logic [1:0] MODE_SCROLL = 2'b10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [DW-1:0]    r_shadow;
   logic [DW-1:0]    w_shadow_rot;
   logic [CNT_W-1:0] r_cnt;
   logic             r_phase;
   logic [SW-1:0]    r_display;
   logic [SW-1:0]    w_display;
   logic             w_wrap;
   logic [3:0]       w_msnz;

   function automatic logic [6:0] f_glyph(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   // Counter sits at TICK_DIV-1 for exactly one cycle; that cycle is the tick.
   assign w_wrap = (r_cnt == CNT_LAST);

   // Rotate left by one nibble; a single digit rotates onto itself.
   generate
      if (DIGITS == 1) begin : g_rot_one
         assign w_shadow_rot = r_shadow;
      end else begin : g_rot_many
         assign w_shadow_rot = {r_shadow[DW-5:0], r_shadow[DW-1 -: 4]};
      end
   endgenerate

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (bus.load || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Load has priority over a coincident tick: no rotate, no phase toggle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_shadow <= '0;
      end else if (bus.load) begin
         r_shadow <= bus.data;
      end else if (w_wrap && (bus.mode == MODE_SCROLL)) begin
         r_shadow <= w_shadow_rot;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_phase <= 1'b0;
      end else if (bus.load || (bus.mode != MODE_BLINK)) begin
         r_phase <= 1'b0;
      end else if (w_wrap) begin
         r_phase <= ~r_phase;
      end
   end

   // Index of the most significant non-zero nibble; 0 when all zero so digit 0
   // always stays lit.
   always_comb begin
      w_msnz = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_shadow[4*k +: 4] != 4'h0) begin
            w_msnz = 4'(k);
         end
      end
   end

   always_comb begin
      w_display = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_phase || (bus.lz_blank && (4'(k) > w_msnz))) begin
            w_display[7*k +: 7] = 7'h7F;
         end else begin
            w_display[7*k +: 7] = f_glyph(r_shadow[4*k +: 4]);
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_display <= '1;
      end else begin
         r_display <= w_display;
      end
   end

   assign bus.tick    = w_wrap;
   assign bus.display = r_display;

`ifdef HEX_DP_EN
   logic [DIGITS-1:0] r_dp;
   logic [DIGITS-1:0] w_dp_rot;
   logic [DIGITS-1:0] r_dp_n;

   generate
      if (DIGITS == 1) begin : g_dp_rot_one
         assign w_dp_rot = r_dp;
      end else begin : g_dp_rot_many
         assign w_dp_rot = {r_dp[DIGITS-2:0], r_dp[DIGITS-1]};
      end
   endgenerate

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_dp <= '0;
      end else if (bus.load) begin
         r_dp <= bus.dp_in;
      end else if (w_wrap && (bus.mode == MODE_SCROLL)) begin
         r_dp <= w_dp_rot;
      end
   end

   // Decimal points follow blink but ignore leading-zero blanking.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_dp_n <= '1;
      end else begin
         r_dp_n <= r_phase ? '1 : ~r_dp;
      end
   end

   assign bus.dp_n = r_dp_n;
`endif

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned TD     = 4;
   localparam int unsigned CNT_W  = 3;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   hex_display_driver_if #(.DIGITS(DIGITS)) bus ();

   hex_display_driver #(
      .DIGITS  (DIGITS),
      .TICK_DIV(TD),
      .CNT_W   (CNT_W)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [6:0] glyph_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Reference model: the value last loaded, cycles elapsed since that load,
   // and the tick index at which the current mode was entered.
   logic [15:0] m_data;
   logic [3:0]  m_dp;
   logic [1:0]  m_mode;
   int          m_since;
   int          m_off;
   logic [27:0] m_exp;
   logic [3:0]  m_dp_exp;
   logic        m_tick_exp;

   function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
      logic [15:0] r = v;
      for (int i = 0; i < n % 4; i++) r = {r[11:0], r[15:12]};
      return r;
   endfunction

   function automatic logic [3:0] rotdp(input logic [3:0] v, input int n);
      logic [3:0] r = v;
      for (int i = 0; i < n % 4; i++) r = {r[2:0], r[3]};
      return r;
   endfunction

   function automatic logic [27:0] glyphs(input logic [15:0] v);
      logic [27:0] r;
      for (int k = 0; k < 4; k++) r[7*k +: 7] = glyph_tab[v[4*k +: 4]];
      return r;
   endfunction

   function automatic int ticks_in_mode();
      return m_since / TD - m_off;
   endfunction

   function automatic logic model_blank();
      return (m_mode == 2'b01) && (ticks_in_mode() % 2 == 1);
   endfunction

   function automatic logic [15:0] model_value();
      return (m_mode == 2'b10) ? rotl(m_data, ticks_in_mode()) : m_data;
   endfunction

   function automatic logic [27:0] render(input logic lz);
      logic [15:0] v = model_value();
      logic [27:0] r = glyphs(v);
      int top = 0;
      for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 0) top = k;
      for (int k = 0; k < 4; k++)
         if (model_blank() || (lz && k > top)) r[7*k +: 7] = 7'h7F;
      return r;
   endfunction

   task automatic model_reset();
      m_data = '0; m_dp = '0; m_mode = 2'b00; m_since = 0; m_off = 0;
   endtask

   // One clock: drive inputs, predict the registered display, advance the model.
   task automatic cyc(input logic ld, input logic [15:0] dat, input logic [1:0] md,
                      input logic lz, input logic [3:0] dpi);
      bus.load = ld; bus.data = dat; bus.mode = md; bus.lz_blank = lz;
`ifdef HEX_DP_EN
      bus.dp_in = dpi;
`endif
      m_exp    = render(lz);
      m_dp_exp = model_blank() ? 4'hF :
                 ~((m_mode == 2'b10) ? rotdp(m_dp, ticks_in_mode()) : m_dp);
      @(posedge clock);
      if (ld) begin
         m_data = dat; m_dp = dpi; m_mode = md; m_since = 0; m_off = 0;
      end else begin
         if (md != m_mode) begin
            if (m_mode == 2'b10) begin
               m_data = rotl(m_data, ticks_in_mode());
               m_dp   = rotdp(m_dp, ticks_in_mode());
            end
            m_off  = m_since / TD;
            m_mode = md;
         end
         m_since++;
      end
      m_tick_exp = (m_since % TD) == TD - 1;
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.load = 1'b0; bus.data = '0; bus.mode = 2'b00; bus.lz_blank = 1'b0;
`ifdef HEX_DP_EN
      bus.dp_in = '0;
`endif
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (bus.display !== 28'hFFFFFFF) begin
         errors++; $display("FAIL reset_display got %h want %h", bus.display, 28'hFFFFFFF);
      end
      @(negedge clock);
      resetn = 1'b1;
      cyc(1'b0, 16'h0, 2'b00, 1'b0, 4'h0);
      checks++;
      if (bus.display !== {4{7'b1000000}}) begin
         errors++; $display("FAIL reset_first_clock got %h want %h", bus.display, {4{7'b1000000}});
      end
      // Mid-count asynchronous reset.
      cyc(1'b1, 16'h9ABC, 2'b10, 1'b0, 4'h5);
      repeat (2) cyc(1'b0, 16'h0, 2'b10, 1'b0, 4'h0);
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.display !== 28'hFFFFFFF || bus.tick !== 1'b0) begin
         errors++; $display("FAIL reset_async got %h/%b want %h/0", bus.display, bus.tick, 28'hFFFFFFF);
      end
`ifdef HEX_DP_EN
      checks++;
      if (bus.dp_n !== 4'hF) begin
         errors++; $display("FAIL reset_dp got %b want 1111", bus.dp_n);
      end
`endif
      bus.mode = 2'b00;
      model_reset();
      @(negedge clock);
      resetn = 1'b1;
      cyc(1'b0, 16'h0, 2'b00, 1'b1, 4'h0);
      checks++;
      if (bus.display !== m_exp || bus.display !== {{3{7'h7F}}, 7'b1000000}) begin
         errors++; $display("FAIL reset_release_lz got %h want %h", bus.display, m_exp);
      end
   endtask

   task automatic test_static();
      int pulses = 0;
      logic [27:0] want = {7'b1111001, 7'b0001000, 7'b0000000, 7'b0001110};
      cyc(1'b1, 16'h1A8F, 2'b00, 1'b0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 16'h0, 2'b00, 1'b0, 4'h0);
         checks++;
         if (bus.display !== want) begin
            errors++; $display("FAIL static_display cyc %0d got %h want %h", i, bus.display, want);
         end
         checks++;
         if (bus.tick !== m_tick_exp) begin
            errors++; $display("FAIL static_tick cyc %0d got %b want %b", i, bus.tick, m_tick_exp);
         end
         if (bus.tick === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 2) begin
         errors++; $display("FAIL static_tick_count got %0d want 2", pulses);
      end
   endtask

   task automatic test_lz();
      cyc(1'b1, 16'h0040, 2'b00, 1'b1, 4'h0);
      cyc(1'b0, 16'h0, 2'b00, 1'b1, 4'h0);
      checks++;
      if (bus.display !== {7'h7F, 7'h7F, 7'b0011001, 7'b1000000}) begin
         errors++; $display("FAIL lz_0040 got %h want %h", bus.display,
                            {7'h7F, 7'h7F, 7'b0011001, 7'b1000000});
      end
      cyc(1'b1, 16'h0000, 2'b00, 1'b1, 4'h0);
      cyc(1'b0, 16'h0, 2'b00, 1'b1, 4'h0);
      checks++;
      if (bus.display !== {{3{7'h7F}}, 7'b1000000}) begin
         errors++; $display("FAIL lz_0000 got %h want %h", bus.display, {{3{7'h7F}}, 7'b1000000});
      end
   endtask

   task automatic test_blink();
      logic [27:0] want;
      cyc(1'b1, 16'h1234, 2'b01, 1'b0, 4'h3);
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b0, 16'h0, 2'b01, 1'b0, 4'h0);
         want = (((i - 1) / 4) % 2 == 1) ? 28'hFFFFFFF : glyphs(16'h1234);
         checks++;
         if (bus.display !== want) begin
            errors++; $display("FAIL blink cyc %0d got %h want %h", i, bus.display, want);
         end
`ifdef HEX_DP_EN
         checks++;
         if (bus.dp_n !== (((i - 1) / 4) % 2 == 1 ? 4'hF : 4'hC)) begin
            errors++; $display("FAIL blink_dp cyc %0d got %b", i, bus.dp_n);
         end
`endif
      end
      // Now in phase 1 (blank); a load restarts at phase 0, counter 0.
      cyc(1'b0, 16'h0, 2'b01, 1'b0, 4'h0);
      cyc(1'b1, 16'h5678, 2'b01, 1'b0, 4'h0);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 16'h0, 2'b01, 1'b0, 4'h0);
         checks++;
         if (bus.display !== glyphs(16'h5678) || bus.tick !== (i == 3)) begin
            errors++; $display("FAIL blink_reload cyc %0d got %h/%b want %h/%b", i,
                               bus.display, bus.tick, glyphs(16'h5678), (i == 3));
         end
      end
   endtask

   task automatic test_scroll();
      logic [15:0] seq [4] = '{16'h2341, 16'h3412, 16'h4123, 16'h1234};
      logic [3:0]  dps [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      cyc(1'b1, 16'h1234, 2'b10, 1'b0, 4'b0001);
      cyc(1'b0, 16'h0, 2'b10, 1'b0, 4'h0);
`ifdef HEX_DP_EN
      checks++;
      if (bus.dp_n !== 4'b1110) begin
         errors++; $display("FAIL scroll_dp0 got %b want 1110", bus.dp_n);
      end
`endif
      for (int t = 0; t < 4; t++) begin
         repeat (4) cyc(1'b0, 16'h0, 2'b10, 1'b0, 4'h0);
         checks++;
         if (bus.display !== glyphs(seq[t])) begin
            errors++; $display("FAIL scroll_step %0d got %h want %h", t, bus.display, glyphs(seq[t]));
         end
`ifdef HEX_DP_EN
         checks++;
         if (bus.dp_n !== dps[t]) begin
            errors++; $display("FAIL scroll_dp %0d got %b want %b", t, bus.dp_n, dps[t]);
         end
`endif
      end
      // Now one cycle before a tick edge? Advance until tick is high, then load.
      for (int i = 0; i < 4 && bus.tick !== 1'b1; i++) cyc(1'b0, 16'h0, 2'b10, 1'b0, 4'h0);
      cyc(1'b1, 16'hBEEF, 2'b10, 1'b0, 4'h0);
      cyc(1'b0, 16'h0, 2'b10, 1'b0, 4'h0);
      checks++;
      if (bus.display !== glyphs(16'hBEEF)) begin
         errors++; $display("FAIL scroll_load_tick got %h want %h", bus.display, glyphs(16'hBEEF));
      end
      // Leaving scroll freezes the rotation.
      repeat (4) cyc(1'b0, 16'h0, 2'b10, 1'b0, 4'h0);
      for (int i = 0; i < 9; i++) begin
         cyc(1'b0, 16'h0, 2'b00, 1'b0, 4'h0);
         checks++;
         if (bus.display !== glyphs(16'hEEFB)) begin
            errors++; $display("FAIL scroll_freeze cyc %0d got %h want %h", i, bus.display,
                               glyphs(16'hEEFB));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      for (int i = 0; i < 10; i++) begin
         d = 16'($urandom);
         cyc(1'b1, d, 2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom));
         checks++;
         if (bus.display !== m_exp || bus.tick !== 1'b0) begin
            errors++; $display("FAIL b2b cyc %0d got %h/%b want %h/0", i, bus.display, bus.tick, m_exp);
         end
      end
   endtask

   task automatic test_random();
      logic       ld;
      logic [1:0] md;
      for (int s = 0; s < 30; s++) begin
         cyc(1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom));
         for (int i = 0; i < int'($urandom_range(1, 14)); i++) begin
            ld = ($urandom_range(0, 9) == 0);
            md = (ld || $urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : m_mode;
            cyc(ld, 16'($urandom), md, 1'($urandom), 4'($urandom));
            checks++;
            if (bus.display !== m_exp) begin
               errors++; $display("FAIL random_display seg %0d got %h want %h", s, bus.display, m_exp);
            end
            checks++;
            if (bus.tick !== m_tick_exp) begin
               errors++; $display("FAIL random_tick seg %0d got %b want %b", s, bus.tick, m_tick_exp);
            end
`ifdef HEX_DP_EN
            checks++;
            if (bus.dp_n !== m_dp_exp) begin
               errors++; $display("FAIL random_dp seg %0d got %b want %b", s, bus.dp_n, m_dp_exp);
            end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_lz();
      test_blink();
      test_scroll();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
